ex_stage_mc: RTL and testbench

Parametrised execute stage of the MINA CPU pipeline, sitting between the ID/EX and EX/MEM registers. It resolves operands through the forwarding unit's selects, runs single-cycle ALU ops combinationally, and runs multiply/divide ops on an iterative multi-cycle unit. While an iterative op is in flight it stalls the front of the pipeline and issues bubbles to EX/MEM. It also passes load/store parameters through to the MEM stage.

---
 rtl/ex_stage_mc_pkg.sv | 47 ++++
 rtl/ex_stage_mc_mdu_iter.sv | 135 +++++++++++++
 rtl/ex_stage_mc.sv | 87 ++++++++
 tb/tb_ex_stage_mc.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/ex_stage_mc_pkg.sv
// ex_stage_mc_pkg: shared types for the MINA execute stage
// Contents: alu_op_e, op_sel_e, fw_sel_e, mem_op_e, mdu_state_e,
//           ex_params_t / mem_params_t (sized by XLEN / RADDR_W),
//           is_iter() which tells whether an op runs on the multi-cycle unit.
// Config:   EX_STAGE_DIV_EN selects whether DIV/DIVU/REM/REMU are iterative.
package ex_stage_mc_pkg;
    localparam int XLEN    = 32;
    localparam int RADDR_W = 5;

    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA,
        ALU_SLT, ALU_SLTU, ALU_MUL, ALU_MULH, ALU_MULHU, ALU_DIV, ALU_DIVU,
        ALU_REM, ALU_REMU
    } alu_op_e;

    typedef enum logic [1:0] {SEL_IA4, SEL_IMM, SEL_REG} op_sel_e;
    typedef enum logic [1:0] {FW_NONE, FW_EX_MEM, FW_MEM_WB} fw_sel_e;
    typedef enum logic [1:0] {MEM_OP_NONE, MEM_OP_LOAD, MEM_OP_STORE} mem_op_e;
    typedef enum logic [1:0] {MDU_IDLE, MDU_BUSY, MDU_DONE} mdu_state_e;

    typedef struct packed {
        alu_op_e             alu_op;
        op_sel_e             a_sel;
        op_sel_e             b_sel;
        logic [XLEN-1:0]     ra_data;
        logic [XLEN-1:0]     rb_data;
        logic [XLEN-1:0]     imm;
        logic [XLEN-1:0]     ia_plus_4;
        logic [RADDR_W-1:0]  rd_addr;
        mem_op_e             mem_op;
    } ex_params_t;

    typedef struct packed {
        logic [RADDR_W-1:0]  rd_addr;
        logic [XLEN-1:0]     rd_data;
        mem_op_e             mem_op;
        logic [XLEN-1:0]     mem_data;
    } mem_params_t;

    function automatic logic is_iter(alu_op_e op);
`ifdef EX_STAGE_DIV_EN
        return op inside {ALU_MUL, ALU_MULH, ALU_MULHU, ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
`else
        return op inside {ALU_MUL, ALU_MULH, ALU_MULHU};
`endif
    endfunction
endpackage

// File: rtl/ex_stage_mc_mdu_iter.sv
// ex_stage_mc_mdu_iter: iterative radix-2 multiplier / restoring divider
// Ports: clk, rst (sync, active-high); start (accepted only in IDLE), flush (abort to IDLE);
//        op, a, b operands sampled on accept; busy (BUSY state), done (DONE state, one cycle);
//        result valid while done.
// Config: EX_STAGE_DIV_EN includes the divider datapath; without it only multiplies run here.
module ex_stage_mc_mdu_iter #(
    parameter int XLEN = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic                     flush,
    input  ex_stage_mc_pkg::alu_op_e op,
    input  logic [XLEN-1:0]          a,
    input  logic [XLEN-1:0]          b,
    output logic                     busy,
    output logic                     done,
    output logic [XLEN-1:0]          result
);
    import ex_stage_mc_pkg::*;
    localparam int CW = $clog2(XLEN);

    mdu_state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    alu_op_e op_q, op_d;
    // mcand: multiplicand or divisor magnitude; shreg: multiplier/product-low or dividend/quotient;
    // acc: product-high or partial remainder
    logic [XLEN-1:0] mcand_q, mcand_d, shreg_q, shreg_d, acc_q, acc_d;
    logic neg_q, neg_d;
    logic signed_in, sa, sb, div_in, div_op, last;
    logic [XLEN-1:0] abs_a, abs_b;
    logic [XLEN:0] mul_sum;
    logic [2*XLEN-1:0] prod_s;
`ifdef EX_STAGE_DIV_EN
    logic div0_q, div0_d, div_ge;
    logic [XLEN:0] div_sh;
    logic [XLEN-1:0] div_rem, quo, rem;
`endif

    always_comb begin
        signed_in = op inside {ALU_MULH, ALU_DIV, ALU_REM};
        sa = signed_in && a[XLEN-1];
        sb = signed_in && b[XLEN-1];
        abs_a = sa ? -a : a;
        abs_b = sb ? -b : b;
        mul_sum = {1'b0, acc_q} + (shreg_q[0] ? {1'b0, mcand_q} : '0);
        last = cnt_q == CW'(XLEN - 1);
        prod_s = neg_q ? -{acc_q, shreg_q} : {acc_q, shreg_q};
`ifdef EX_STAGE_DIV_EN
        div_in = op inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
        div_op = op_q inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
        div_sh = {acc_q, shreg_q[XLEN-1]};
        div_ge = div_sh >= {1'b0, mcand_q};
        div_rem = div_ge ? XLEN'(div_sh - {1'b0, mcand_q}) : div_sh[XLEN-1:0];
        // a zero divisor naturally leaves the dividend as remainder; only the quotient needs forcing
        quo = div0_q ? '1 : neg_q ? -shreg_q : shreg_q;
        rem = neg_q ? -acc_q : acc_q;
        result = op_q == ALU_MUL ? prod_s[XLEN-1:0] :
                 op_q inside {ALU_MULH, ALU_MULHU} ? prod_s[2*XLEN-1:XLEN] :
                 op_q inside {ALU_DIV, ALU_DIVU} ? quo : rem;
        div0_d = div0_q;
`else
        div_in = 1'b0;
        div_op = 1'b0;
        result = op_q == ALU_MUL ? prod_s[XLEN-1:0] : prod_s[2*XLEN-1:XLEN];
`endif
        state_d = state_q;
        cnt_d = cnt_q;
        op_d = op_q;
        mcand_d = mcand_q;
        shreg_d = shreg_q;
        acc_d = acc_q;
        neg_d = neg_q;
        case (state_q)
            MDU_IDLE: if (start) begin
                state_d = MDU_BUSY;
                cnt_d = '0;
                op_d = op;
                mcand_d = div_in ? abs_b : abs_a;
                shreg_d = div_in ? abs_a : abs_b;
                acc_d = '0;
                // REM takes the dividend's sign; MULH/DIV take the product of signs
                neg_d = op == ALU_REM ? sa : sa ^ sb;
`ifdef EX_STAGE_DIV_EN
                div0_d = b == '0;
`endif
            end
            MDU_BUSY: begin
                cnt_d = cnt_q + 1'b1;
                state_d = last ? MDU_DONE : MDU_BUSY;
`ifdef EX_STAGE_DIV_EN
                acc_d = div_op ? div_rem : mul_sum[XLEN:1];
                shreg_d = div_op ? {shreg_q[XLEN-2:0], div_ge} : {mul_sum[0], shreg_q[XLEN-1:1]};
`else
                acc_d = div_op ? acc_q : mul_sum[XLEN:1];
                shreg_d = {mul_sum[0], shreg_q[XLEN-1:1]};
`endif
            end
            default: state_d = MDU_IDLE;
        endcase
        if (flush) begin
            state_d = MDU_IDLE;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MDU_IDLE;
            cnt_q <= '0;
            op_q <= ALU_ADD;
            mcand_q <= '0;
            shreg_q <= '0;
            acc_q <= '0;
            neg_q <= 1'b0;
`ifdef EX_STAGE_DIV_EN
            div0_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
            op_q <= op_d;
            mcand_q <= mcand_d;
            shreg_q <= shreg_d;
            acc_q <= acc_d;
            neg_q <= neg_d;
`ifdef EX_STAGE_DIV_EN
            div0_q <= div0_d;
`endif
        end
    end

    assign busy = state_q == MDU_BUSY;
    assign done = state_q == MDU_DONE;
endmodule

// File: rtl/ex_stage_mc.sv
// ex_stage_mc: MINA execute stage with single-cycle ALU and iterative multiply/divide
// Ports: clk, rst (sync, active-high); in_valid + ex_params from ID/EX; ra_sel/rb_sel with
//        rd_data_ex_mem / rd_data_mem_wb forwarding; flush kills the EX instruction;
//        stall holds IF/ID/ID-EX; out_valid + mem_params feed EX/MEM (zero when not valid).
// Config: EX_STAGE_DIV_EN enables the divider; otherwise DIV/DIVU/REM/REMU return 0 in one cycle.
// XLEN/RADDR_W must match the package constants that size the parameter structs.
module ex_stage_mc #(
    parameter int XLEN    = 32,
    parameter int RADDR_W = 5
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         in_valid,
    input  ex_stage_mc_pkg::ex_params_t  ex_params,
    input  ex_stage_mc_pkg::fw_sel_e     ra_sel,
    input  ex_stage_mc_pkg::fw_sel_e     rb_sel,
    input  logic [XLEN-1:0]              rd_data_ex_mem,
    input  logic [XLEN-1:0]              rd_data_mem_wb,
    input  logic                         flush,
    output logic                         stall,
    output logic                         out_valid,
    output ex_stage_mc_pkg::mem_params_t mem_params
);
    import ex_stage_mc_pkg::*;
    localparam int SW = $clog2(XLEN);

    logic [XLEN-1:0] ra_fw, rb_fw, op_a, op_b, alu_res, mdu_res;
    logic [SW-1:0] shamt;
    logic iter, start, busy, done, idle;
    logic [RADDR_W-1:0] rd_addr_q, rd_addr_d;

    always_comb begin
        ra_fw = ra_sel == FW_EX_MEM ? rd_data_ex_mem : ra_sel == FW_MEM_WB ? rd_data_mem_wb : ex_params.ra_data;
        rb_fw = rb_sel == FW_EX_MEM ? rd_data_ex_mem : rb_sel == FW_MEM_WB ? rd_data_mem_wb : ex_params.rb_data;
        op_a = ex_params.a_sel == SEL_IA4 ? ex_params.ia_plus_4 : ex_params.a_sel == SEL_IMM ? ex_params.imm : ra_fw;
        op_b = ex_params.b_sel == SEL_IA4 ? ex_params.ia_plus_4 : ex_params.b_sel == SEL_IMM ? ex_params.imm : rb_fw;
        shamt = op_b[SW-1:0];
        case (ex_params.alu_op)
            ALU_ADD:  alu_res = op_a + op_b;
            ALU_SUB:  alu_res = op_a - op_b;
            ALU_AND:  alu_res = op_a & op_b;
            ALU_OR:   alu_res = op_a | op_b;
            ALU_XOR:  alu_res = op_a ^ op_b;
            ALU_SLL:  alu_res = op_a << shamt;
            ALU_SRL:  alu_res = op_a >> shamt;
            ALU_SRA:  alu_res = $signed(op_a) >>> shamt;
            ALU_SLT:  alu_res = XLEN'($signed(op_a) < $signed(op_b));
            ALU_SLTU: alu_res = XLEN'(op_a < op_b);
            default:  alu_res = '0;
        endcase
        iter = is_iter(ex_params.alu_op);
        start = in_valid && iter && !flush;
        idle = !busy && !done;
        stall = busy || (idle && start);
        rd_addr_d = idle && start ? ex_params.rd_addr : rd_addr_q;
        // DONE presents the iterative result; the still-held ID/EX copy of that op is ignored
        out_valid = !flush && (done || (idle && in_valid && !iter));
        mem_params = '0;
        if (out_valid && done) begin
            mem_params.rd_addr = rd_addr_q;
            mem_params.rd_data = mdu_res;
        end else if (out_valid) begin
            mem_params.rd_addr = ex_params.rd_addr;
            mem_params.rd_data = ex_params.mem_op != MEM_OP_NONE ? op_a + op_b : alu_res;
            mem_params.mem_op = ex_params.mem_op;
            mem_params.mem_data = rb_fw;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) rd_addr_q <= '0;
        else rd_addr_q <= rd_addr_d;
    end

    ex_stage_mc_mdu_iter #(.XLEN(XLEN)) u_mdu (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .flush  (flush),
        .op     (ex_params.alu_op),
        .a      (op_a),
        .b      (op_b),
        .busy   (busy),
        .done   (done),
        .result (mdu_res)
    );
endmodule

// File: tb/tb_ex_stage_mc.sv
// tb_ex_stage_mc: directed self-checking bench for ex_stage_mc
module tb_ex_stage_mc;
    import ex_stage_mc_pkg::*;

    logic clk = 1'b0;
    logic rst, in_valid, flush, stall, out_valid;
    ex_params_t ep;
    fw_sel_e ra_sel, rb_sel;
    logic [31:0] fem, fmw;
    mem_params_t mp;
    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    ex_stage_mc dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .ex_params      (ep),
        .ra_sel         (ra_sel),
        .rb_sel         (rb_sel),
        .rd_data_ex_mem (fem),
        .rd_data_mem_wb (fmw),
        .flush          (flush),
        .stall          (stall),
        .out_valid      (out_valid),
        .mem_params     (mp)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_rr(input alu_op_e op, input logic [31:0] a, input logic [31:0] b);
        ep = '0;
        ep.alu_op = op;
        ep.a_sel = SEL_REG;
        ep.b_sel = SEL_REG;
        ep.ra_data = a;
        ep.rb_data = b;
        ep.rd_addr = 5'd3;
        ra_sel = FW_NONE;
        rb_sel = FW_NONE;
        in_valid = 1'b1;
    endtask

    task automatic single(input string tag, input logic [31:0] exp);
        #1;
        check({tag, "_stall"}, stall, 0);
        check({tag, "_ov"}, out_valid, 1);
        check(tag, mp.rd_data, exp);
        @(negedge clk);
    endtask

    // operand a arrives via EX_MEM forwarding, which is scrambled every stall cycle
    task automatic run_iter(input string tag, input alu_op_e op, input logic [31:0] a,
                            input logic [31:0] b, input logic [31:0] exp);
        int n = 0;
        int ov = 0;
        set_rr(op, 32'hDEAD_BEEF, b);
        ra_sel = FW_EX_MEM;
        fem = a;
        #1;
        while (stall && n < 100) begin
            n++;
            if (out_valid) ov++;
            @(negedge clk);
            fem = $urandom;
            fmw = $urandom;
            #1;
        end
        check({tag, "_stall_cycles"}, n, 33);
        check({tag, "_ov_in_stall"}, ov, 0);
        check({tag, "_ov"}, out_valid, 1);
        check({tag, "_rd_addr"}, mp.rd_addr, 3);
        check(tag, mp.rd_data, exp);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check({tag, "_ov_once"}, out_valid, 0);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        flush = 1'b0;
        ep = '0;
        ra_sel = FW_NONE;
        rb_sel = FW_NONE;
        fem = '0;
        fmw = '0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_stall", stall, 0);
        check("rst_ov", out_valid, 0);
        check("rst_mp", mp != '0, 0);
        rst = 1'b0;
        @(negedge clk);

        set_rr(ALU_ADD, 99, 3); ra_sel = FW_EX_MEM; fem = 7; fmw = 55;
        single("add_fw_exmem", 10);
        set_rr(ALU_ADD, 99, 3); ra_sel = FW_MEM_WB; fmw = 20;
        single("add_fw_memwb", 23);
        set_rr(ALU_SUB, 0, 0); ep.a_sel = SEL_IA4; ep.b_sel = SEL_IMM; ep.ia_plus_4 = 32'h104; ep.imm = 4;
        single("sub_ia4_imm", 32'h100);
        set_rr(ALU_SRA, 32'h8000_0000, 32'h24);
        single("sra", 32'hF800_0000);
        set_rr(ALU_SRL, 32'h8000_0000, 32'h24);
        single("srl", 32'h0800_0000);
        set_rr(ALU_SLL, 1, 33);
        single("sll", 2);
        set_rr(ALU_SLT, 32'hFFFF_FFFF, 1);
        single("slt", 1);
        set_rr(ALU_SLTU, 32'hFFFF_FFFF, 1);
        single("sltu", 0);
        set_rr(ALU_XOR, 32'hF0F0, 32'hFF00);
        single("xor", 32'h0FF0);

        set_rr(ALU_ADD, 32'h1000, 5); ep.b_sel = SEL_IMM; ep.imm = 32'h10; ep.mem_op = MEM_OP_LOAD;
        ep.rd_addr = 5'd17; rb_sel = FW_MEM_WB; fmw = 32'hABCD;
        #1;
        check("ld_addr", mp.rd_data, 32'h1010);
        check("ld_data", mp.mem_data, 32'hABCD);
        check("ld_op", mp.mem_op, MEM_OP_LOAD);
        check("ld_rd", mp.rd_addr, 17);
        @(negedge clk);

        set_rr(ALU_ADD, 1, 2); flush = 1'b1;
        #1;
        check("flush_single_ov", out_valid, 0);
        @(negedge clk);
        set_rr(ALU_MUL, 5, 6);
        #1;
        check("flush_accept_stall", stall, 0);
        check("flush_accept_ov", out_valid, 0);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0;
        #1;
        check("flush_accept_idle", stall, 0);
        @(negedge clk);

        run_iter("mulhu", ALU_MULHU, 32'hFFFF_FFFF, 2, 1);
        run_iter("mul", ALU_MUL, 32'hFFFF_FFFF, 2, 32'hFFFF_FFFE);
        run_iter("mulh_neg", ALU_MULH, 32'hFFFF_FFFD, 5, 32'hFFFF_FFFF);
        run_iter("mul_neg", ALU_MUL, 32'hFFFF_FFFD, 5, 32'hFFFF_FFF1);
        run_iter("mulh_min", ALU_MULH, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
`ifdef EX_STAGE_DIV_EN
        run_iter("divu", ALU_DIVU, 100, 7, 14);
        run_iter("remu", ALU_REMU, 100, 7, 2);
        run_iter("div_by0", ALU_DIV, 100, 0, 32'hFFFF_FFFF);
        run_iter("rem_by0", ALU_REM, 100, 0, 100);
        run_iter("div_neg_by0", ALU_DIV, 32'hFFFF_FF9C, 0, 32'hFFFF_FFFF);
        run_iter("rem_neg_by0", ALU_REM, 32'hFFFF_FF9C, 0, 32'hFFFF_FF9C);
        run_iter("div_ovf", ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_iter("rem_ovf", ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_iter("div_neg", ALU_DIV, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFD);
        run_iter("rem_neg", ALU_REM, 32'hFFFF_FFF9, 2, 32'hFFFF_FFFF);
`else
        set_rr(ALU_DIV, 9, 3);
        single("div_off", 0);
        set_rr(ALU_REMU, 9, 4);
        single("remu_off", 0);
        run_iter("mul_off", ALU_MUL, 9, 3, 27);
`endif

        set_rr(ALU_MUL, 5, 6);
        #1;
        check("fl_accept_stall", stall, 1);
        repeat (11) @(negedge clk);
        flush = 1'b1;
        #1;
        check("fl_busy_stall", stall, 1);
        check("fl_busy_ov", out_valid, 0);
        @(negedge clk);
        flush = 1'b0;
        set_rr(ALU_ADD, 1, 1);
        single("fl_next_add", 2);
        in_valid = 1'b0;
        begin
            int ov = 0;
            int st = 0;
            repeat (40) begin
                #1;
                if (out_valid) ov++;
                if (stall) st++;
                @(negedge clk);
            end
            check("fl_no_result", ov, 0);
            check("fl_no_stall", st, 0);
        end

        set_rr(ALU_MUL, 5, 5);
        repeat (6) @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rs_stall", stall, 0);
        check("rs_ov", out_valid, 0);
        check("rs_mp", mp != '0, 0);
        @(negedge clk);
        run_iter("rs_mul", ALU_MUL, 3, 4, 12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
